// File: rtl/rf_writeback_queue.sv
// In-order writeback queue feeding the register file's single write port, with forwarding lookup.
// Optional build macro RF_WB_COALESCE_EN: same-register mem+alu pairs collapse into the alu entry.
module rf_writeback_queue #(
    parameter int DEPTH    = 4,
    parameter int NUM_REGS = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [3:0]               alu_reg,
    input  logic [7:0]               alu_data,
    input  logic                     mem_valid,
    input  logic [3:0]               mem_reg,
    input  logic [7:0]               mem_data,
    output logic                     wb_stall,
    output logic                     rf_write_reg,
    output logic [3:0]               rf_reg_in,
    output logic [7:0]               rf_write_data,
    input  logic [3:0]               fwd_reg,
    output logic                     fwd_hit,
    output logic [7:0]               fwd_data,
    output logic [$clog2(DEPTH):0]   pending_count,
    output logic                     bad_index
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);

    logic [3:0]    reg_q  [DEPTH];
    logic [7:0]    data_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;
    logic          bad_q, bad_d;

    logic          accept, pop, mem_ok, alu_ok, coalesce, push_mem, push_alu;
    logic [PW-1:0] alu_slot;

    // free = DEPTH - count + (count != 0) drops below 2 only when the queue is completely full.
    assign wb_stall = (count_q == CW'(DEPTH));
    assign accept   = !wb_stall;
    assign pop      = (count_q != '0);

    assign mem_ok = mem_valid && ({1'b0, mem_reg} < NUM_REGS_W);
    assign alu_ok = alu_valid && ({1'b0, alu_reg} < NUM_REGS_W);

`ifdef RF_WB_COALESCE_EN
    assign coalesce = mem_ok && alu_ok && (mem_reg == alu_reg);
`else
    assign coalesce = 1'b0;
`endif

    assign push_mem = accept && mem_ok && !coalesce;
    assign push_alu = accept && alu_ok;
    assign alu_slot = tail_q + PW'(push_mem);

    assign bad_d   = accept && ((mem_valid && !mem_ok) || (alu_valid && !alu_ok));
    assign count_d = count_q + CW'(push_mem) + CW'(push_alu) - CW'(pop);

    assign rf_write_reg  = pop;
    assign rf_reg_in     = pop ? reg_q[head_q]  : 4'd0;
    assign rf_write_data = pop ? data_q[head_q] : 8'd0;
    assign pending_count = count_q;
    assign bad_index     = bad_q;

    always_comb begin : fwd_lookup
        logic [PW-1:0] slot;
        // NOTE: every comb output gets a default before any condition, so no latch is inferred.
        fwd_hit  = 1'b0;
        fwd_data = 8'd0;
        slot     = '0;
        // Walk oldest to youngest so the youngest match overwrites earlier ones.
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_q + PW'(i);
            if ((CW'(i) < count_q) && (reg_q[slot] == fwd_reg)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[slot];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            bad_q   <= 1'b0;
            // NOTE: storage is cleared too; it is tiny and keeps stale entries from ever being observable.
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= 4'd0;
                data_q[i] <= 8'd0;
            end
        end else begin
            if (push_mem) begin
                reg_q[tail_q]  <= mem_reg;
                data_q[tail_q] <= mem_data;
            end
            if (push_alu) begin
                reg_q[alu_slot]  <= alu_reg;
                data_q[alu_slot] <= alu_data;
            end
            tail_q  <= tail_q + PW'(push_mem) + PW'(push_alu);
            head_q  <= head_q + PW'(pop);
            count_q <= count_d;
            bad_q   <= bad_d;
        end
    end

endmodule

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
- Writeback stage directly upstream of the 8-bit, 14-entry register file.
- Collects results from two producers, the ALU and the memory-load path, into a small in-order queue.
- Drains one entry per cycle onto the register file's single write port (rf_write_reg / rf_reg_in / rf_write_data).
- Provides a forwarding lookup for pending writes and back-pressures producers when the queue is nearly full.

Parameters:
- DEPTH, 4: number of queue entries; power of two, minimum 2.
- NUM_REGS, 14: number of implemented registers; indices >= NUM_REGS are invalid.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_reg  in  4  ALU destination register index.
- alu_data  in  8  ALU result.
- mem_valid  in  1  load result present this cycle.
- mem_reg  in  4  load destination register index.
- mem_data  in  8  load data.
- wb_stall  out  1  producers must hold; inputs are not accepted while high.
- rf_write_reg  out  1  register-file write enable.
- rf_reg_in  out  4  register-file write index.
- rf_write_data  out  8  register-file write data.
- fwd_reg  in  4  register index to look up.
- fwd_hit  out  1  a queued entry targets fwd_reg.
- fwd_data  out  8  data of the youngest queued entry targeting fwd_reg; 0 when no hit.
- pending_count  out  $clog2(DEPTH)+1  number of valid queue entries.
- bad_index  out  1  one-cycle pulse: an accepted input had an index >= NUM_REGS.

Behaviour:
- Reset (synchronous, active-high) clears the following on the next edge:
  - queue contents, head/tail pointers, pending_count -> 0;
  - bad_index -> 0.
  - Consequently rf_write_reg=0, rf_reg_in=0, rf_write_data=0, fwd_hit=0, fwd_data=0.
  - Reset mid-operation discards all queued writes; none reach the register file.
- Queue head drives the write port combinationally:
  - rf_write_reg = (pending_count != 0); rf_reg_in / rf_write_data = head entry, else 0.
- Pop: every cycle with pending_count != 0, the head is removed at the edge. The register file commits it at that same edge.
- Latency: an input accepted at edge N with an empty queue is on the write port during cycle N+1 and committed at edge N+1.
- Stall:
  - free = DEPTH - pending_count + (pending_count != 0 ? 1 : 0).
  - wb_stall = (free < 2).
  - It depends only on registered state, so there is no combinational path from the valid inputs.
- Accept (when wb_stall=0):
  - each valid input is enqueued at the edge;
  - if both are valid, the mem entry is enqueued first (older), then the alu entry;
  - same-cycle pop and push are allowed; pending_count updates by pushes minus pop.
- While wb_stall=1, inputs are ignored. The producer must keep valid and data stable until wb_stall falls.
- Invalid index (reg >= NUM_REGS) on an accepted input:
  - the input is not enqueued;
  - bad_index is high for exactly the following cycle;
  - the other input in the same cycle is unaffected.
- Same destination from both inputs in one cycle: both are enqueued, mem then alu, so the register's final value is alu_data.
- Forwarding:
  - purely combinational over valid queued entries only; the current cycle's inputs are not included;
  - with multiple matches, the youngest entry (closest to tail) wins;
  - the head entry still counts as a hit during its commit cycle.
- Pointer wrap: head and tail wrap modulo DEPTH. Full/empty are distinguished by pending_count, never by pointer equality.

Optional Feature:
- RF_WB_COALESCE_EN defined: if alu_valid and mem_valid are both accepted with equal valid indices, only the alu entry is enqueued; pending_count grows by 1. Stall rule unchanged.
- Undefined: both entries are enqueued as described in Behaviour.

Test Plan:
- Reset, then alu_valid=1, alu_reg=3, alu_data=8'hA5 for one cycle -> next cycle rf_write_reg=1, rf_reg_in=3, rf_write_data=A5; one cycle later rf_write_reg=0, pending_count=0.
- Same cycle: mem_reg=5/8'h11 and alu_reg=5/8'h22 -> write port shows 5/11 then 5/22 on consecutive cycles. With RF_WB_COALESCE_EN: only 5/22, pending_count peaks at 1.
- DEPTH=4, both inputs valid every cycle with distinct regs -> wb_stall asserts once free < 2. No entry lost or duplicated; RF write order equals mem-before-alu acceptance order.
- Queue holds reg 7 = 8'h01 then reg 7 = 8'h02; fwd_reg=7 -> fwd_hit=1, fwd_data=02. fwd_reg=9 -> fwd_hit=0, fwd_data=00.
- alu_reg=14 with mem_reg=2/8'h33 in the same cycle -> bad_index high for one cycle; only 2/33 is written.
- Three entries queued, then reset asserted for one cycle -> next cycle rf_write_reg=0 and pending_count=0; no queued entry is ever written.
